// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants: opcodes, NOP encoding, FSM state codes and the buffer entry layout.
package riscv_pkg;

    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    // Fetch FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    // One buffered fetch result handed to Decode
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions; synchronous clear, occupancy count output.
module fetch_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Wrap a pointer at DEPTH so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Entry storage, data only (no reset needed)
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, 2-entry buffer, flush redirect, BTFN prediction.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          BTFN_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_prediction,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_branch_pc
);

    import riscv_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_nxt;
    logic             accept;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic [6:0]       opcode;
    logic [31:0]      imm_b;
    logic [31:0]      imm_j;
    logic             is_jal;
    logic             pred;
    logic [31:0]      next_pc;

    // A request goes out only when the buffer has room for its response
    assign o_imem_req  = (state == S_REQ) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign o_imem_addr = fetch_pc;
    assign accept      = o_imem_req && i_imem_ready;

    // Static BTFN prediction from the returning instruction word
    always_comb begin
        opcode  = i_imem_rdata[6:0];
        imm_b   = {{20{i_imem_rdata[31]}}, i_imem_rdata[7], i_imem_rdata[30:25],
                   i_imem_rdata[11:8], 1'b0};
        imm_j   = {{12{i_imem_rdata[31]}}, i_imem_rdata[19:12], i_imem_rdata[20],
                   i_imem_rdata[30:21], 1'b0};
        is_jal  = (opcode == OPCODE_JAL);
        pred    = BTFN_EN && (is_jal || ((opcode == OPCODE_BRANCH) && imm_b[12]));
        next_pc = (pred ? fetch_pc + (is_jal ? imm_j : imm_b) : fetch_pc + 32'd4) & ~32'd3;
    end

    // Next-state, next-PC and push decision; a flush overrides everything
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        fifo_push    = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  if (accept) state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    fifo_push    = 1'b1;
                    fetch_pc_nxt = next_pc;
                    state_nxt    = S_REQ;
                end
            end
            S_DROP: if (i_imem_rvalid) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
        if (i_flush) begin
            fifo_push    = 1'b0;
            fetch_pc_nxt = i_branch_pc & ~32'd3;
            // Anything in flight for the old path must be swallowed
            if (((state == S_REQ) && accept) || ((state == S_WAIT) && !i_imem_rvalid))
                state_nxt = S_DROP;
        end
    end

    // FSM state and fetch PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    assign push_entry = '{instr: i_imem_rdata, pc: fetch_pc, pred: pred};
    assign fifo_pop   = !fifo_empty && !i_stall;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (i_flush),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign o_valid      = !fifo_empty;
    assign o_instr      = o_valid ? head.instr : NOP_INSTR;
    assign o_pc         = o_valid ? head.pc : 32'd0;
    assign o_prediction = o_valid && head.pred;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one BTFN-enabled instance plus a BTFN-disabled twin.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic        stall;
    logic        flush;
    logic [31:0] branch_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        prediction;

    logic        nb_req;
    logic [31:0] nb_addr;
    logic        nb_rvalid;
    logic [31:0] nb_rdata;
    logic        nb_valid;
    logic [31:0] nb_instr;
    logic [31:0] nb_pc;
    logic        nb_prediction;

    logic        auto1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .NOP_INSTR  (32'h0000_0013),
        .FIFO_DEPTH (2),
        .BTFN_EN    (1'b1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ready  (imem_ready),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_valid       (valid),
        .o_instr       (instr),
        .o_pc          (pc),
        .o_prediction  (prediction),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_branch_pc   (branch_pc)
    );

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .NOP_INSTR  (32'h0000_0013),
        .FIFO_DEPTH (2),
        .BTFN_EN    (1'b0)
    ) u_dut_nb (
        .clk           (clk),
        .rst           (rst),
        .o_imem_req    (nb_req),
        .o_imem_addr   (nb_addr),
        .i_imem_ready  (imem_ready),
        .i_imem_rvalid (nb_rvalid),
        .i_imem_rdata  (nb_rdata),
        .o_valid       (nb_valid),
        .o_instr       (nb_instr),
        .o_pc          (nb_pc),
        .o_prediction  (nb_prediction),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_branch_pc   (branch_pc)
    );

    // Instruction memory contents: three control-flow words, addi x0,x0,addr elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h0043_1663;
            32'h0000_0020: return 32'hFE00_0CE3;
            32'h0000_0040: return 32'h0100_00EF;
            default:       return {a[11:0], 20'h00013};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock; memory answers an accepted request at the following negedge
    task automatic cycle();
        logic        acc1;
        logic        acc2;
        logic [31:0] a1;
        logic [31:0] a2;
        acc1 = imem_req && imem_ready;
        a1   = imem_addr;
        acc2 = nb_req && imem_ready;
        a2   = nb_addr;
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        nb_rvalid   = 1'b0;
        if (acc1 && auto1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(a1);
        end
        if (acc2) begin
            nb_rvalid = 1'b1;
            nb_rdata  = mem_word(a2);
        end
    endtask

    // Redirect both instances, then check the first instruction each delivers
    task automatic redirect_check(input string tag, input logic [31:0] tgt,
                                  input logic [31:0] next1, input logic pred1,
                                  input logic [31:0] next2);
        logic got1;
        logic got2;
        flush     = 1'b1;
        branch_pc = tgt;
        cycle();
        flush = 1'b0;
        got1  = 1'b0;
        got2  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (!got1 && valid) begin
                got1 = 1'b1;
                chk({tag, "_pc"}, pc, tgt);
                chk({tag, "_instr"}, instr, mem_word(tgt));
                chk1({tag, "_pred"}, prediction, pred1);
                chk({tag, "_next"}, imem_addr, next1);
            end
            if (!got2 && nb_valid) begin
                got2 = 1'b1;
                chk1({tag, "_nb_pred"}, nb_prediction, 1'b0);
                chk({tag, "_nb_next"}, nb_addr, next2);
            end
            if (got1 && got2) break;
            cycle();
        end
        chk1({tag, "_arrived"}, got1, 1'b1);
        chk1({tag, "_nb_arrived"}, got2, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        imem_ready  = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        branch_pc   = 32'd0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        nb_rvalid   = 1'b0;
        nb_rdata    = 32'd0;
        auto1       = 1'b1;

        // Reset values
        @(negedge clk);
        chk1("rst_valid", valid, 1'b0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'd0);
        chk1("rst_pred", prediction, 1'b0);
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'd0);
        chk1("rst_nb_valid", nb_valid, 1'b0);

        // 1: sequential fetch, 1-cycle memory latency
        rst = 1'b0;
        cycle();
        chk1("t1_req0", imem_req, 1'b1);
        chk("t1_addr0", imem_addr, 32'h0);
        cycle();
        chk1("t1_wait_req", imem_req, 1'b0);
        chk1("t1_empty", valid, 1'b0);
        chk("t1_nop", instr, 32'h0000_0013);
        cycle();
        chk1("t1_valid0", valid, 1'b1);
        chk("t1_pc0", pc, 32'h0);
        chk("t1_instr0", instr, 32'h0000_0013);
        chk("t1_addr4", imem_addr, 32'h4);
        cycle();
        chk1("t1_popped", valid, 1'b0);
        cycle();
        chk("t1_pc4", pc, 32'h4);
        chk("t1_addr8", imem_addr, 32'h8);
        cycle();
        cycle();
        chk1("t1_valid8", valid, 1'b1);
        chk("t1_pc8", pc, 32'h8);
        chk("t1_instr8", instr, mem_word(32'h8));
        chk("t1_addr12", imem_addr, 32'hC);

        // 2: stall six cycles fills the buffer and blocks requests
        stall = 1'b1;
        cycle();
        cycle();
        chk1("t2_full_req", imem_req, 1'b0);
        chk("t2_pc_head", pc, 32'h8);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk1("t2_req_hold", imem_req, 1'b0);
            chk("t2_pc_hold", pc, 32'h8);
            chk("t2_instr_hold", instr, mem_word(32'h8));
        end
        stall = 1'b0;
        cycle();
        chk("t2_pc12", pc, 32'hC);
        chk("t2_instr12", instr, mem_word(32'hC));
        chk1("t2_req_resume", imem_req, 1'b1);
        chk("t2_addr16", imem_addr, 32'h10);
        cycle();
        chk1("t2_drained", valid, 1'b0);
        cycle();
        chk("t2_pc16", pc, 32'h10);
        chk("t2_addr20", imem_addr, 32'h14);

        // 3: flush in WAIT, stale response arrives late
        auto1 = 1'b0;
        cycle();
        chk1("t3_wait", imem_req, 1'b0);
        flush     = 1'b1;
        branch_pc = 32'h100;
        cycle();
        flush = 1'b0;
        chk1("t3_drop_req", imem_req, 1'b0);
        chk1("t3_flushed", valid, 1'b0);
        chk("t3_addr", imem_addr, 32'h100);
        cycle();
        chk1("t3_drop_hold", imem_req, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h14);
        auto1       = 1'b1;
        cycle();
        chk1("t3_req", imem_req, 1'b1);
        chk("t3_addr100", imem_addr, 32'h100);
        chk1("t3_stale_dropped", valid, 1'b0);
        cycle();
        cycle();
        chk1("t3_valid", valid, 1'b1);
        chk("t3_pc100", pc, 32'h100);
        chk("t3_instr100", instr, mem_word(32'h100));

        // 4: flush coincident with rvalid, unaligned target
        cycle();
        flush     = 1'b1;
        branch_pc = 32'h103;
        cycle();
        flush = 1'b0;
        chk1("t4_no_drop", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 32'h100);
        chk1("t4_dropped", valid, 1'b0);
        cycle();
        cycle();
        chk1("t4_valid", valid, 1'b1);
        chk("t4_pc", pc, 32'h100);

        // 5: BTFN prediction, enabled vs disabled
        redirect_check("t5_beq", 32'h20, 32'h18, 1'b1, 32'h24);
        redirect_check("t5_bne", 32'h10, 32'h14, 1'b0, 32'h14);
        redirect_check("t5_jal", 32'h40, 32'h50, 1'b1, 32'h44);

        // 6: reset while a response is outstanding
        auto1 = 1'b0;
        cycle();
        chk1("t6_in_wait", imem_req, 1'b0);
        rst = 1'b1;
        #1;
        chk1("t6_rst_valid", valid, 1'b0);
        chk("t6_rst_instr", instr, 32'h0000_0013);
        chk("t6_rst_pc", pc, 32'd0);
        chk1("t6_rst_pred", prediction, 1'b0);
        chk1("t6_rst_req", imem_req, 1'b0);
        chk("t6_rst_addr", imem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        cycle();
        chk1("t6_req", imem_req, 1'b1);
        chk("t6_addr0", imem_addr, 32'h0);
        chk1("t6_stale_ignored", valid, 1'b0);
        auto1 = 1'b1;
        cycle();
        cycle();
        chk1("t6_valid", valid, 1'b1);
        chk("t6_pc0", pc, 32'h0);
        chk("t6_instr0", instr, 32'h0000_0013);
        chk("t6_addr4", imem_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
